// File: rtl/sequence_recorder.sv
// Multi-channel edge-triggered word recorder: captures one word per store
// rising edge and writes it to a memory port in round-robin order.
module sequence_recorder #(
    parameter int WORD_SIZE    = 8,
    parameter int ADDRESS_SIZE = 4,
    parameter int MEMORY_QTY   = 16,
    parameter int CHANNELS     = 2,
    parameter int WRAP         = 0,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [CHANNELS-1:0]           store_i,
    input  logic [CHANNELS*WORD_SIZE-1:0] sequence_i,
    input  logic                          clear_i,
    input  logic                          w_ready_i,
    output logic                          w_en_o,
    output logic [ADDRESS_SIZE-1:0]       w_addr_o,
    output logic [WORD_SIZE-1:0]          w_data_o,
    output logic [CW-1:0]                 w_chan_o,
    output logic [ADDRESS_SIZE:0]         count_o,
    output logic                          full_o,
    output logic                          dropped_o
);

    localparam logic [ADDRESS_SIZE:0]   QTY  = (ADDRESS_SIZE+1)'(MEMORY_QTY);
    localparam logic [ADDRESS_SIZE-1:0] LAST = ADDRESS_SIZE'(MEMORY_QTY - 1);
    localparam logic [CW-1:0]           CH_LAST = CW'(CHANNELS - 1);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                  state_q;
    logic [CHANNELS-1:0]     store_q;
    logic [CHANNELS-1:0]     pending_q;
    logic [CHANNELS-1:0]     pending_d;
    logic [CHANNELS-1:0]     edge_w;
    logic [WORD_SIZE-1:0]    hold_q [CHANNELS];
    logic [CW-1:0]           rr_q;
    logic [CW-1:0]           rr_next;
    logic [CW-1:0]           grant_d;
    logic [ADDRESS_SIZE-1:0] wr_ptr_q;
    logic [ADDRESS_SIZE-1:0] wr_ptr_next;
    logic [ADDRESS_SIZE:0]   count_q;
    logic                    clr_q;
    logic                    w_en_q;
    logic [ADDRESS_SIZE-1:0] w_addr_q;
    logic [WORD_SIZE-1:0]    w_data_q;
    logic [CW-1:0]           w_chan_q;
    logic                    dropped_q;
    logic                    dropped_d;
    logic                    found;
    logic                    low_done;
    logic                    full_w;
    logic                    idle_w;
    logic                    complete;
    logic                    zero_w;
    logic                    can_grant;
    logic                    drop_full;

    assign edge_w    = store_i & ~store_q;
    assign full_w    = (count_q == QTY);
    assign idle_w    = (state_q == IDLE);
    assign complete  = (state_q == WRITE) && w_ready_i;
    assign zero_w    = (idle_w && clear_i) || (complete && (clr_q || clear_i));
    assign can_grant = idle_w && !clear_i && (|pending_q)
                       && ((WRAP != 0) || !full_w);
    assign drop_full = idle_w && !clear_i && (|pending_q)
                       && (WRAP == 0) && full_w;

    assign rr_next     = (w_chan_q == CH_LAST) ? '0 : w_chan_q + 1'b1;
    assign wr_ptr_next = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;

    // Round-robin: first pending at or above rr, else first pending overall.
    always_comb begin
        found   = 1'b0;
        grant_d = '0;
        for (int j = 0; j < CHANNELS; j++) begin
            if (!found && pending_q[j] && (CW'(j) >= rr_q)) begin
                found   = 1'b1;
                grant_d = CW'(j);
            end
        end
        for (int j = 0; j < CHANNELS; j++) begin
            if (!found && pending_q[j]) begin
                found   = 1'b1;
                grant_d = CW'(j);
            end
        end
    end

    // Completion and full-drops release slots first so a same-cycle edge wins.
    always_comb begin
        pending_d = pending_q;
        dropped_d = drop_full;
        low_done  = 1'b0;
        for (int j = 0; j < CHANNELS; j++) begin
            if (complete && (w_chan_q == CW'(j)))
                pending_d[j] = 1'b0;
        end
        for (int j = 0; j < CHANNELS; j++) begin
            if (drop_full && !low_done && pending_q[j]) begin
                pending_d[j] = 1'b0;
                low_done     = 1'b1;
            end
        end
        for (int j = 0; j < CHANNELS; j++) begin
            if (edge_w[j]) begin
                if (pending_d[j])
                    dropped_d = 1'b1;
                pending_d[j] = 1'b1;
            end
        end
        if (zero_w)
            pending_d = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            store_q   <= '0;
            pending_q <= '0;
            for (int j = 0; j < CHANNELS; j++)
                hold_q[j] <= '0;
            rr_q      <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            clr_q     <= 1'b0;
            w_en_q    <= 1'b0;
            w_addr_q  <= '0;
            w_data_q  <= '0;
            w_chan_q  <= '0;
            dropped_q <= 1'b0;
        end else begin
            store_q   <= store_i;
            pending_q <= pending_d;
            dropped_q <= dropped_d;
            for (int j = 0; j < CHANNELS; j++) begin
                if (edge_w[j])
                    hold_q[j] <= sequence_i[j*WORD_SIZE +: WORD_SIZE];
            end
            unique case (state_q)
                IDLE: begin
                    if (clear_i) begin
                        rr_q     <= '0;
                        wr_ptr_q <= '0;
                        count_q  <= '0;
                    end else if (can_grant) begin
                        w_en_q   <= 1'b1;
                        w_addr_q <= wr_ptr_q;
                        w_data_q <= hold_q[grant_d];
                        w_chan_q <= grant_d;
                        clr_q    <= 1'b0;
                        state_q  <= WRITE;
                    end
                end
                WRITE: begin
                    if (clear_i)
                        clr_q <= 1'b1;
                    if (w_ready_i) begin
                        w_en_q  <= 1'b0;
                        clr_q   <= 1'b0;
                        state_q <= IDLE;
                        if (clr_q || clear_i) begin
                            rr_q     <= '0;
                            wr_ptr_q <= '0;
                            count_q  <= '0;
                        end else begin
                            rr_q     <= rr_next;
                            wr_ptr_q <= wr_ptr_next;
                            if (!full_w)
                                count_q <= count_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign w_en_o    = w_en_q;
    assign w_addr_o  = w_addr_q;
    assign w_data_o  = w_data_q;
    assign w_chan_o  = w_chan_q;
    assign count_o   = count_q;
    assign full_o    = full_w;
    assign dropped_o = dropped_q;

endmodule
